// File: rtl/spi_sub_sync.sv
// SPI subordinate running entirely on i_clk: cs/sclk/sdi are synchronised and sclk edges detected,
// so clock polarity, phase and frame width are build-time parameters.
//
// state  | meaning
// IDLE   | waiting for synced cs to fall
// ACTIVE | frame in progress, sampling/shifting on sclk edges
// DONE   | DATA_W bits received, extra edges ignored until cs rises
module spi_sub_sync #(
    parameter int DATA_W      = 128,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_sclk,
    input  logic              i_sdi,
    output logic              o_sdo,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_load,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_tx_buf;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_sdi;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [DATA_W-1:0]      w_rx_next;

    // Synchroniser reset values match the idle bus, so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_sdi_sync  <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= CPOL;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
            r_cs_d      <= w_cs;
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdi     = r_sdi_sync[SYNC_STAGES-1];
    assign w_lead    = (w_sclk != CPOL) && (r_sclk_d == CPOL);
    assign w_trail   = (w_sclk == CPOL) && (r_sclk_d != CPOL);
    assign w_sample  = CPHA ? w_trail : w_lead;
    assign w_shift   = CPHA ? w_lead : w_trail;
    assign w_cs_fall = !w_cs && r_cs_d;
    assign w_cs_rise = w_cs && !r_cs_d;
    assign w_rx_next = {r_rx_shift[DATA_W-2:0], w_sdi};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_tx_buf    <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (i_tx_load) begin
                r_tx_buf <= i_tx_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= ST_ACTIVE;
                        r_bit_cnt  <= '0;
                        r_tx_shift <= r_tx_buf;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_sample) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end else if (w_shift && (r_bit_cnt != '0)) begin
                        // First shift edge is skipped so the MSB is held until the first sample.
                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sdo       = (r_state == ST_ACTIVE) && r_tx_shift[DATA_W-1];
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_sub_sync.sv
// Bench for spi_sub_sync: one 128-bit default instance plus four 8-bit instances covering every
// CPOL/CPHA mode, driven by a behavioural SPI main and checked against a frame-level model.
module tb_spi_sub_sync;

    localparam int NI   = 5;
    localparam int HALF = 50;

    logic         clk;
    logic         rst;
    logic         cs        [NI];
    logic         sclk      [NI];
    logic         sdi       [NI];
    logic         tx_load   [NI];
    logic [127:0] tx_data   [NI];
    logic         sdo       [NI];
    logic         rx_valid  [NI];
    logic         frame_err [NI];
    logic         busy      [NI];
    logic [127:0] rx_data   [NI];

    int n_assert = 0;
    int n_fail   = 0;
    int rx_cnt  [NI] = '{default: 0};
    int err_cnt [NI] = '{default: 0};

    logic [127:0] m_txbuf  [NI];
    logic [127:0] m_rx     [NI];
    int           m_rxcnt  [NI] = '{default: 0};
    int           m_errcnt [NI] = '{default: 0};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW    = (g == 0) ? 128 : 8;
        localparam bit PCPOL = (g == 0) ? 1'b0 : 1'(((g - 1) >> 1) & 1);
        localparam bit PCPHA = (g == 0) ? 1'b1 : 1'((g - 1) & 1);
        logic [DW-1:0] w_rx;
        spi_sub_sync #(
            .DATA_W(DW), .CPOL(PCPOL), .CPHA(PCPHA), .SYNC_STAGES(2)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_cs       (cs[g]),
            .i_sclk     (sclk[g]),
            .i_sdi      (sdi[g]),
            .o_sdo      (sdo[g]),
            .i_tx_data  (tx_data[g][DW-1:0]),
            .i_tx_load  (tx_load[g]),
            .o_rx_data  (w_rx),
            .o_rx_valid (rx_valid[g]),
            .o_frame_err(frame_err[g]),
            .o_busy     (busy[g])
        );
        assign rx_data[g] = 128'(w_rx);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rx_valid[k])  rx_cnt[k]++;
            if (frame_err[k]) err_cnt[k]++;
        end
    end

    function automatic int dw_of(input int k);
        return (k == 0) ? 128 : 8;
    endfunction

    function automatic bit cpol_of(input int k);
        return (k == 0) ? 1'b0 : 1'(((k - 1) >> 1) & 1);
    endfunction

    function automatic bit cpha_of(input int k);
        return (k == 0) ? 1'b1 : 1'((k - 1) & 1);
    endfunction

    function automatic logic [127:0] mask(input int n);
        logic [127:0] one;
        one = 128'd1;
        if (n >= 128) return '1;
        return (one << n) - 128'd1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input int k, input logic [127:0] d);
        tx_data[k] = d;
        tx_load[k] = 1'b1;
        m_txbuf[k] = d & mask(dw_of(k));
        #10;
        tx_load[k] = 1'b0;
    endtask

    // Behavioural SPI main: drives ncyc full sclk cycles, captures sdo on the mode's sample edge.
    task automatic spi_frame(input int k, input logic [127:0] word, input int ncyc,
                             output logic [127:0] cap);
        int  dw;
        bit  pol, pha;
        dw  = dw_of(k);
        pol = cpol_of(k);
        pha = cpha_of(k);
        cap = '0;
        sclk[k] = pol;
        if (!pha) sdi[k] = word[dw-1];
        cs[k] = 1'b0;
        #HALF;
        for (int b = 0; b < ncyc; b++) begin
            if (pha) sdi[k] = (b < dw) ? word[dw-1-b] : 1'b0;
            else     cap = {cap[126:0], sdo[k]};
            sclk[k] = ~pol;
            #HALF;
            if (pha) cap = {cap[126:0], sdo[k]};
            else     sdi[k] = (b + 1 < dw) ? word[dw-2-b] : 1'b0;
            sclk[k] = pol;
            #HALF;
        end
        cs[k]  = 1'b1;
        sdi[k] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic run_frame(input int k, input logic [127:0] word, input int ncyc,
                             input string tag);
        logic [127:0] txs, cap, expc;
        int dw;
        dw  = dw_of(k);
        txs = m_txbuf[k];
        spi_frame(k, word, ncyc, cap);
        if (ncyc >= dw) begin
            m_rxcnt[k]++;
            m_rx[k] = word & mask(dw);
            expc = txs << (ncyc - dw);
        end else begin
            m_errcnt[k]++;
            expc = txs >> (dw - ncyc);
        end
        chk($sformatf("%s miso", tag), cap & mask(ncyc), expc & mask(ncyc));
        chk($sformatf("%s rx_data", tag), rx_data[k], m_rx[k]);
        chk($sformatf("%s rx_cnt", tag), 128'(rx_cnt[k]), 128'(m_rxcnt[k]));
        chk($sformatf("%s err_cnt", tag), 128'(err_cnt[k]), 128'(m_errcnt[k]));
        chk($sformatf("%s busy", tag), 128'(busy[k]), 128'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w, cap;
        int k, nc;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            cs[i] = 1'b1; sclk[i] = cpol_of(i); sdi[i] = 1'b0;
            tx_load[i] = 1'b0; tx_data[i] = '0;
            m_txbuf[i] = '0; m_rx[i] = '0;
        end
        #23;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset%0d rx_data", i), rx_data[i], 128'd0);
            chk($sformatf("reset%0d outs", i),
                128'({sdo[i], rx_valid[i], frame_err[i], busy[i]}), 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Default build, full frame both ways.
        load(0, 128'h00112233445566778899AABBCCDDEEFF);
        run_frame(0, 128'h0123456789ABCDEF_FEDCBA9876543210, 128, "t1");

        // 8-bit builds in all four modes.
        for (int i = 1; i < NI; i++) begin
            load(i, 128'h3C);
            run_frame(i, 128'hA5, 8, $sformatf("t2m%0d", i - 1));
        end

        // Truncated frame then recovery.
        run_frame(0, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 77, "t3short");
        run_frame(0, 128'h55AA55AA_0F0F0F0F_F0F0F0F0_A5A5A5A5, 128, "t3full");

        // Extra sclk cycles beyond the frame.
        run_frame(0, 128'h89ABCDEF_01234567_76543210_FEDCBA98, 130, "t4");

        // Load mid-frame only affects the following frame.
        load(2, 128'h0F);
        fork
            run_frame(2, 128'h96, 8, "t5cur");
            begin #(HALF * 7); load(2, 128'hF0); end
        join
        run_frame(2, 128'h69, 8, "t5next");

        // Reset in the middle of a frame.
        fork
            spi_frame(0, 128'hFFFF0000_FFFF0000_12121212_34343434, 128, cap);
            begin
                #(HALF * (1 + 2 * 40));
                chk("t6 busy before rst", 128'(busy[0]), 128'd1);
                rst = 1'b1;
                #1;
                chk("t6 rx_data in rst", rx_data[0], 128'd0);
                chk("t6 outs in rst",
                    128'({sdo[0], rx_valid[0], frame_err[0], busy[0]}), 128'd0);
            end
        join
        for (int i = 0; i < NI; i++) begin
            m_rx[i] = '0;
            m_txbuf[i] = '0;
        end
        #20;
        rst = 1'b0;
        #20;
        chk("t6 rx_cnt after rst", 128'(rx_cnt[0]), 128'(m_rxcnt[0]));
        run_frame(0, 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978, 128, "t6plain");
        load(0, 128'hC001D00D_0BADF00D_FEEDFACE_8BADF00D);
        run_frame(0, 128'hA5A5_5A5A_3C3C_C3C3_0000_FFFF_1234_5678, 128, "t6full");

        // Randomised frames on the 8-bit builds.
        for (int it = 0; it < 24; it++) begin
            k = $urandom_range(NI - 1, 1);
            if ($urandom_range(0, 2) == 0) load(k, 128'($urandom_range(0, 255)));
            w = 128'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)      nc = $urandom_range(0, 7);
            else if ($urandom_range(0, 4) == 0) nc = 8 + $urandom_range(1, 3);
            else                                nc = 8;
            run_frame(k, w, nc, $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
